// File: rtl/half_mul_stream_rx.sv
// half_mul_stream_rx
//   Receiving end of the row-streaming matrix operand protocol. A start beat
//   plus DIM-1 consecutive beats deliver A row k and B column k on beat k.
//   Both operands are buffered. C = A*B is then computed one row per cycle,
//   and the result is presented with per-element overflow flags.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   start_bit  marks beat 0 of a new operand stream
//   a_row_i    packed A beat (slot 0 at MSB, DATA_WIDTH per slot)
//   b_col_i    packed B beat (slot k*DIM+j carries B[j][k])
//   busy       high in LOAD and COMP
//   done_o     one-cycle pulse when the result is complete
//   ouflow_o   per-element overflow flags (slot 0 at MSB)
//   fin_r_o    packed result matrix C (slot 0 at MSB, BUS_WIDTH per slot)
//
// Build option:
//   HALF_MUL_STREAM_RX_SATURATE_EN - when defined, an overflowing element
//   saturates to all-ones. Otherwise it wraps. The flag is set in both cases.
//
// state | meaning
// IDLE  | waiting for start_bit
// LOAD  | capturing operand beats 1..DIM-1
// COMP  | writing result row row_q
// DONE  | result complete, done_o high; start_bit restarts immediately
module half_mul_stream_rx #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_bit,
  input  logic [DIM*BUS_WIDTH-1:0]       a_row_i,
  input  logic [DIM*BUS_WIDTH-1:0]       b_col_i,
  output logic                           busy,
  output logic                           done_o,
  output logic [DIM*DIM-1:0]             ouflow_o,
  output logic [DIM*DIM*BUS_WIDTH-1:0]   fin_r_o
);

  localparam int NS     = DIM * DIM;
  localparam int ACC_W  = 2 * DATA_WIDTH + 2;
  localparam int WIDE_W = ACC_W + BUS_WIDTH;
  localparam int CW     = (DIM > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         beat_q, row_q;
  logic [DATA_WIDTH-1:0] a_q   [DIM][DIM];
  logic [DATA_WIDTH-1:0] b_q   [DIM][DIM];
  logic [BUS_WIDTH-1:0]  fin_q [DIM][DIM];
  logic                  ov_q  [DIM][DIM];

  logic [DATA_WIDTH-1:0] a_slot [NS];
  logic [DATA_WIDTH-1:0] b_slot [NS];
  logic [BUS_WIDTH-1:0]  row_val [DIM];
  logic                  row_ov  [DIM];

  logic                  cap_en, clr_en, wr_en;
  logic [CW-1:0]         cap_idx;

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      a_slot[s] = a_row_i[(NS-1-s)*DATA_WIDTH +: DATA_WIDTH];
      b_slot[s] = b_col_i[(NS-1-s)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    clr_en  = 1'b0;
    wr_en   = 1'b0;
    cap_idx = beat_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_bit) begin
          cap_en  = 1'b1;
          clr_en  = 1'b1;
          cap_idx = '0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cap_en = 1'b1;
        if (beat_q == CW'(DIM-1)) state_d = COMP;
      end
      COMP: begin
        wr_en = 1'b1;
        if (row_q == CW'(DIM-1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Dot products for the row being written. The accumulator is wide enough
  // for DIM<=4 full-scale products, so overflow is judged on its upper bits.
  always_comb begin
    logic [ACC_W-1:0]  acc;
    logic [WIDE_W-1:0] wide;
    for (int j = 0; j < DIM; j++) begin
      acc = '0;
      for (int k = 0; k < DIM; k++) begin
        acc = acc + ACC_W'(a_q[row_q][k]) * ACC_W'(b_q[k][j]);
      end
      wide      = WIDE_W'(acc);
      row_ov[j] = (wide >> BUS_WIDTH) != '0;
`ifdef HALF_MUL_STREAM_RX_SATURATE_EN
      row_val[j] = row_ov[j] ? '1 : wide[BUS_WIDTH-1:0];
`else
      row_val[j] = wide[BUS_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          fin_q[i][j] <= '0;
          ov_q[i][j]  <= 1'b0;
        end
      end
    end else begin
      state_q <= state_d;
      if (clr_en) begin
        beat_q <= CW'(1);
        row_q  <= '0;
      end else if (state_q == LOAD) begin
        beat_q <= beat_q + 1'b1;
      end else if (state_q == COMP) begin
        row_q <= row_q + 1'b1;
      end
      // Beat k: slot k*DIM+j is A[k][j] on one bus and B[j][k] on the other.
      if (cap_en) begin
        for (int j = 0; j < DIM; j++) begin
          a_q[cap_idx][j] <= a_slot[int'(cap_idx)*DIM + j];
          b_q[j][cap_idx] <= b_slot[int'(cap_idx)*DIM + j];
        end
      end
      if (clr_en) begin
        for (int i = 0; i < DIM; i++) begin
          for (int j = 0; j < DIM; j++) begin
            fin_q[i][j] <= '0;
            ov_q[i][j]  <= 1'b0;
          end
        end
      end else if (wr_en) begin
        for (int j = 0; j < DIM; j++) begin
          fin_q[row_q][j] <= row_val[j];
          ov_q[row_q][j]  <= row_ov[j];
        end
      end
    end
  end

  assign busy   = (state_q == LOAD) || (state_q == COMP);
  assign done_o = (state_q == DONE);

  always_comb begin
    fin_r_o  = '0;
    ouflow_o = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        fin_r_o[(NS-1-(i*DIM+j))*BUS_WIDTH +: BUS_WIDTH] = fin_q[i][j];
        ouflow_o[NS-1-(i*DIM+j)] = ov_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_half_mul_stream_rx.sv
// Bench for half_mul_stream_rx: a DIM=4 instance is checked every cycle
// against a matrix-level model, and two DIM=2 instances get directed
// literal checks (narrow operands and 16-bit full-scale overflow).
module tb_half_mul_stream_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DIM=4: BUS 32, DATA 8
  logic st4;
  logic [127:0] a4, b4;
  logic busy4, done4;
  logic [15:0] ov4;
  logic [511:0] fin4;
  // DIM=2: BUS 16, DATA 8
  logic st2;
  logic [31:0] a2, b2;
  logic busy2, done2;
  logic [3:0] ov2;
  logic [63:0] fin2;
  // DIM=2: BUS 32, DATA 16
  logic st3;
  logic [63:0] a3, b3;
  logic busy3, done3;
  logic [3:0] ov3;
  logic [127:0] fin3;

  half_mul_stream_rx #(.BUS_WIDTH(32), .DATA_WIDTH(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_bit(st4), .a_row_i(a4), .b_col_i(b4),
    .busy(busy4), .done_o(done4), .ouflow_o(ov4), .fin_r_o(fin4));
  half_mul_stream_rx #(.BUS_WIDTH(16), .DATA_WIDTH(8)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_bit(st2), .a_row_i(a2), .b_col_i(b2),
    .busy(busy2), .done_o(done2), .ouflow_o(ov2), .fin_r_o(fin2));
  half_mul_stream_rx #(.BUS_WIDTH(32), .DATA_WIDTH(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_bit(st3), .a_row_i(a3), .b_col_i(b3),
    .busy(busy3), .done_o(done3), .ouflow_o(ov3), .fin_r_o(fin3));

  localparam logic [127:0] A_PACK  = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] ID_PACK = 128'h01000000000100000000010000000001;
  localparam logic [511:0] EXP1 = {
    32'h1E, 32'h46,  32'h6E,  32'h96,
    32'h46, 32'hAE,  32'h116, 32'h17E,
    32'h6E, 32'h116, 32'h1BE, 32'h266,
    32'h96, 32'h17E, 32'h266, 32'h34E};
  localparam logic [511:0] EXP_ID = {
    32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
    32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};
`ifdef HALF_MUL_STREAM_RX_SATURATE_EN
  localparam logic [127:0] EXP_FULL = {4{32'hFFFFFFFF}};
`else
  localparam logic [127:0] EXP_FULL = {4{32'hFFFC0002}};
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 50) $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- matrix-level model of the DIM=4 instance ----------------
  int m_cnt = 0;            // cycles since the accepted start beat; 0 = idle
  longint ma [4][4];
  longint mb [4][4];
  logic [511:0] m_fin = '0;
  logic [15:0]  m_ov  = '0;

  function automatic longint slot4(input logic [127:0] bus, input int s);
    logic [127:0] t;
    t = bus >> ((15 - s) * 8);
    return longint'(t[7:0]);
  endfunction

  task automatic take_beat(input int k);
    for (int j = 0; j < 4; j++) begin
      ma[k][j] = slot4(a4, k*4 + j);
      mb[j][k] = slot4(b4, k*4 + j);
    end
  endtask

  task automatic compute_c();
    longint sum;
    logic [63:0] s64;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sum = 0;
        for (int k = 0; k < 4; k++) sum += ma[i][k] * mb[k][j];
        s64 = 64'(sum);
        m_ov[15 - (i*4 + j)] = (s64 >= 64'h1_0000_0000);
`ifdef HALF_MUL_STREAM_RX_SATURATE_EN
        if (s64 >= 64'h1_0000_0000) s64 = 64'hFFFF_FFFF;
`endif
        m_fin[(15 - (i*4 + j))*32 +: 32] = s64[31:0];
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      m_fin = '0;
      m_ov  = '0;
    end else if ((m_cnt == 0 || m_cnt == 8) && st4) begin
      m_cnt = 1;
      m_fin = '0;
      m_ov  = '0;
      take_beat(0);
    end else if (m_cnt >= 1 && m_cnt <= 7) begin
      if (m_cnt < 4) take_beat(m_cnt);
      m_cnt++;
      if (m_cnt == 8) compute_c();
    end else if (m_cnt == 8) begin
      m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy4", 512'(busy4), 512'(m_cnt >= 1 && m_cnt <= 7));
      chk("done4", 512'(done4), 512'(m_cnt == 8));
      if (m_cnt == 0 || m_cnt == 8) begin
        chk("fin4_model", fin4, m_fin);
        chk("ov4_model", 512'(ov4), 512'(m_ov));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] abuf [4];
  logic [127:0] bbuf [4];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] mixg(input logic [127:0] base, input int k);
    logic [127:0] r;
    r = rnd128();
    for (int s = 0; s < 16; s++)
      if (s / 4 == k) r[(15 - s)*8 +: 8] = base[(15 - s)*8 +: 8];
    return r;
  endfunction

  task automatic run4(input logic [15:0] mask, output int dc, output int nd, output int nb);
    st4 = 1'b1; a4 = abuf[0]; b4 = bbuf[0];
    dc = -1; nd = 0; nb = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      st4 = mask[n];
      if (n < 4) begin a4 = abuf[n]; b4 = bbuf[n]; end
      else begin a4 = rnd128(); b4 = rnd128(); end
      @(negedge clk);
      if (done4) begin nd++; dc = n; end
      if (busy4) nb++;
    end
  endtask

  initial begin
    int dc, nd, nb, dc3, nd3, d1, d2;
    rst = 1'b1;
    st4 = 1'b0; a4 = '0; b4 = '0;
    st2 = 1'b0; a2 = '0; b2 = '0;
    st3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 512'(busy4), 512'(0));
    chk("rst_done", 512'(done4), 512'(0));
    chk("rst_fin", fin4, 512'(0));
    chk("rst_ov", 512'(ov4), 512'(0));
    chk_en = 1'b1;

    // DIM=2 instances: A=[1 2;5 6], B=A^T, and 16-bit all-ones overflow
    st2 = 1'b1; a2 = 32'h01020506; b2 = 32'h01020506;
    st3 = 1'b1; a3 = '1; b3 = '1;
    dc = -1; nd = 0; nb = 0; dc3 = -1; nd3 = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      st2 = 1'b0; st3 = 1'b0;
      @(negedge clk);
      if (done2) begin nd++; dc = n; end
      if (busy2) nb++;
      if (done3) begin nd3++; dc3 = n; end
    end
    chk("d2_done_cycle", 512'(dc), 512'(4));
    chk("d2_done_count", 512'(nd), 512'(1));
    chk("d2_busy_cycles", 512'(nb), 512'(3));
    chk("d2_fin", 512'(fin2), 512'({16'h5, 16'd17, 16'd17, 16'h3D}));
    chk("d2_ov", 512'(ov2), 512'(0));
    chk("d2w_done_cycle", 512'(dc3), 512'(4));
    chk("d2w_done_count", 512'(nd3), 512'(1));
    chk("d2w_fin", 512'(fin3), 512'(EXP_FULL));
    chk("d2w_ov", 512'(ov3), 512'(4'hF));

    // DIM=4, A rows 1..16, B = A^T
    for (int k = 0; k < 4; k++) begin abuf[k] = A_PACK; bbuf[k] = A_PACK; end
    run4(16'h0000, dc, nd, nb);
    chk("s1_done_cycle", 512'(dc), 512'(8));
    chk("s1_done_count", 512'(nd), 512'(1));
    chk("s1_busy_cycles", 512'(nb), 512'(7));
    chk("s1_fin", fin4, EXP1);
    chk("s1_ov", 512'(ov4), 512'(0));

    // same operands, garbage in inactive slots, start re-pulsed in LOAD and COMP
    for (int k = 0; k < 4; k++) begin abuf[k] = mixg(A_PACK, k); bbuf[k] = mixg(A_PACK, k); end
    run4(16'h0024, dc, nd, nb);
    chk("s2_done_cycle", 512'(dc), 512'(8));
    chk("s2_done_count", 512'(nd), 512'(1));
    chk("s2_fin", fin4, EXP1);

    // back-to-back: second stream (B = identity) starts in the DONE cycle
    st4 = 1'b1; a4 = A_PACK; b4 = A_PACK;
    d1 = -1; d2 = -1; nd = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      st4 = (n == 8);
      a4 = A_PACK;
      b4 = (n >= 8) ? ID_PACK : A_PACK;
      @(negedge clk);
      if (done4) begin
        nd++;
        if (d1 < 0) begin d1 = n; chk("b2b_first_fin", fin4, EXP1); end
        else d2 = n;
      end
    end
    chk("b2b_first_done", 512'(d1), 512'(8));
    chk("b2b_second_done", 512'(d2), 512'(16));
    chk("b2b_done_count", 512'(nd), 512'(2));
    chk("b2b_second_fin", fin4, EXP_ID);

    // reset during COMP after row 0 has been written
    st4 = 1'b1; a4 = A_PACK; b4 = A_PACK;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      st4 = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_comp_busy", 512'(busy4), 512'(0));
    chk("rst_comp_fin", fin4, 512'(0));
    chk("rst_comp_done", 512'(done4), 512'(0));
    nd = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    chk("rst_comp_no_done", 512'(nd), 512'(0));

    // fresh streams after the abort, including random operands
    for (int k = 0; k < 4; k++) begin abuf[k] = A_PACK; bbuf[k] = ID_PACK; end
    run4(16'h0000, dc, nd, nb);
    chk("fresh_fin", fin4, EXP_ID);
    chk("fresh_done_cycle", 512'(dc), 512'(8));
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) begin abuf[k] = rnd128(); bbuf[k] = rnd128(); end
      run4(16'h0000, dc, nd, nb);
      chk("rand_done_cycle", 512'(dc), 512'(8));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_mul_stream_rx.md
Name: half_mul_stream_rx

Overview:
- Receiving end of the row-streaming matrix operand protocol.
- A start beat plus DIM-1 further consecutive beats deliver one row of A and one column of B per beat.
- The block buffers both operands, then computes C = A*B one result row per cycle and presents the full result with per-element overflow flags.
- It sits between the operand source (or bench driver) and the result consumer; it is the DUT-side counterpart of the stimulus driver.

Parameters:
- BUS_WIDTH, 32, width of one result element, in bits.
- DATA_WIDTH, 8, width of one unsigned operand element, in bits.
- DIM, BUS_WIDTH/DATA_WIDTH, matrix dimension. Legal values: 2, 3, 4.

Ports:
- clk_i, in, 1: single clock, all logic rising-edge.
- rst_i, in, 1: synchronous, active-high reset.
- start_bit, in, 1: marks beat 0 of a new operand stream.
- a_row_i, in, DIM*BUS_WIDTH: packed A beat. Beat k carries A row k.
- b_col_i, in, DIM*BUS_WIDTH: packed B beat. Beat k carries B column k.
- busy, out, 1: high while loading or computing.
- done_o, out, 1: one-cycle pulse when the result is complete.
- ouflow_o, out, DIM*DIM: per-element overflow flag, same slot order as fin_r_o.
- fin_r_o, out, DIM*DIM*BUS_WIDTH: packed result matrix C.

Behaviour:
- Packing:
  - Operand slot s = r*DIM+c occupies bits [(DIM*DIM-1-s)*DATA_WIDTH +: DATA_WIDTH], so slot 0 is at the MSB.
  - At beat k, only slots k*DIM..k*DIM+DIM-1 of each bus are captured. All other slots are ignored (don't-care, not required zero).
  - For b_col_i, slot k*DIM+j is B[j][k].
  - Result slot i*DIM+j is C[i][j] in [(DIM*DIM-1-s)*BUS_WIDTH +: BUS_WIDTH]; ouflow_o bit DIM*DIM-1-s is its flag.
- Reset: state IDLE; busy=0, done_o=0, ouflow_o=0, fin_r_o=0; operand buffers and counters cleared.
  - Reset mid-LOAD or mid-COMP aborts the operation, emits no done_o, and leaves no partial result.
- FSM states: IDLE, LOAD, COMP, DONE.
  - IDLE or DONE with start_bit=1: capture beat 0, clear fin_r_o and ouflow_o, beat counter=1, go to LOAD (go to COMP directly if DIM==1, which is not legal).
  - LOAD: capture beat counter; increment. After beat DIM-1 is captured, go to COMP with row counter=0.
  - COMP: write result row i (all DIM elements of row i, combinational DIM-term dot products); increment i. After row DIM-1, go to DONE.
  - DONE: done_o=1 for exactly this cycle. Next state is IDLE, or LOAD if start_bit=1 (back-to-back operation is accepted).
- start_bit in LOAD or COMP is ignored: no restart, no error.
- Beats must be on consecutive cycles; there is no stall input.
- busy = state in {LOAD, COMP}, so it is high for exactly 2*DIM-1 cycles per operation. It is low in IDLE and DONE.
- Latency: start beat captured at edge 0; done_o is high in the cycle after edge 2*DIM-1.
  - DIM=4: done_o is high in the 8th cycle after the start beat.
- Arithmetic:
  - Operands are unsigned. Products are 2*DATA_WIDTH bits.
  - Each sum is accumulated at 2*DATA_WIDTH+2 bits.
  - Flag set if the sum is >= 2^BUS_WIDTH. Without the optional feature, the element takes the low BUS_WIDTH bits (wrap).
- fin_r_o and ouflow_o are valid when done_o=1. They hold until the next accepted start_bit or reset.

Optional Feature:
- Macro: HALF_MUL_STREAM_RX_SATURATE_EN.
- Defined: an overflowing element is written as all-ones (2^BUS_WIDTH-1) and its flag is set.
- Undefined: the element wraps to its low BUS_WIDTH bits and its flag is set.
- Flag behaviour and timing are identical in both builds.

Test Plan:
- DIM=4, A = rows 1..16, B = A-transpose (same beats on both buses, start_bit with beat 0).
  - fin_r_o rows = {1E 46 6E 96}, {46 AE 116 17E}, {6E 116 1BE 266}, {96 17E 266 34E}.
  - ouflow_o=0; done_o is a single pulse in the 8th cycle; busy high for 7 cycles.
- DIM=2, A = [1 2; 5 6], B = A-transpose → fin_r_o = {5, 17, 17, 3D}; done_o in the 4th cycle after start.
- DIM=2, DATA_WIDTH=16, BUS_WIDTH=32, all operands FFFF:
  - Undefined build: every element = FFFC0002 with its flag set.
  - Saturate build: every element = FFFFFFFF with its flag set.
- DIM=4, start_bit pulsed again during LOAD and during COMP; nonzero garbage in inactive slots → result identical to the first scenario, exactly one done_o.
- Assert rst_i for one cycle during COMP → next cycle: busy=0, fin_r_o=0, no done_o. A fresh stream then completes correctly.
- Back-to-back: start_bit asserted in the DONE cycle with a new stream → second operation is accepted with no idle gap, and its done_o arrives 2*DIM cycles after the first.
